// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC operation controller: FSM states, op/width codes, masks.
package ecc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENC_ISSUE,
        ENC_CAPTURE,
        DEC_ISSUE,
        DEC_CAPTURE,
        DONE
    } state_t;

    localparam logic [1:0] CTRL_ENC  = 2'd0;
    localparam logic [1:0] CTRL_DEC  = 2'd1;
    localparam logic [1:0] CTRL_FULL = 2'd2;
    localparam logic [1:0] CTRL_RSVD = 2'd3;

    localparam logic [1:0] WIDTH_8    = 2'd0;
    localparam logic [1:0] WIDTH_16   = 2'd1;
    localparam logic [1:0] WIDTH_32   = 2'd2;
    localparam logic [1:0] WIDTH_RSVD = 2'd3;

    localparam logic [31:0] MASK_8  = 32'h0000_00FF;
    localparam logic [31:0] MASK_16 = 32'h0000_FFFF;
    localparam logic [31:0] MASK_32 = 32'hFFFF_FFFF;

endpackage

// File: rtl/ecc_op_ctrl_if.sv
// Host, encoder and decoder signals of the ECC operation controller.
interface ecc_op_ctrl_if #(
    parameter int AMBA_WORD = 32
);
    logic                 start;
    logic [1:0]           ctrl;
    logic [1:0]           codeword_width;
    logic [AMBA_WORD-1:0] data_in;
    logic [AMBA_WORD-1:0] noise;
    logic [AMBA_WORD-1:0] enc_data;
    logic [1:0]           enc_width;
    logic [AMBA_WORD-1:0] enc_out;
    logic [AMBA_WORD-1:0] dec_data;
    logic [AMBA_WORD-1:0] dec_out;
    logic [1:0]           dec_nerr;
    logic                 busy;
    logic [AMBA_WORD-1:0] data_out;
    logic [1:0]           num_of_errors;
    logic                 cfg_err;
    logic                 operation_done;

    modport slave (
        input  start, ctrl, codeword_width, data_in, noise, enc_out, dec_out, dec_nerr,
        output enc_data, enc_width, dec_data, busy, data_out, num_of_errors, cfg_err,
               operation_done
    );

    modport master (
        output start, ctrl, codeword_width, data_in, noise, enc_out, dec_out, dec_nerr,
        input  enc_data, enc_width, dec_data, busy, data_out, num_of_errors, cfg_err,
               operation_done
    );
endinterface

// File: rtl/ecc_width_mask.sv
// Keeps the low 8/16/32 bits of a word according to a codeword width code.
module ecc_width_mask
    import ecc_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] i_data,
    input  logic [1:0]   i_width,
    output logic [W-1:0] o_data
);

    logic [W-1:0] w_mask;

    // The reserved width code never reaches the codec, so it masks everything off.
    always_comb begin
        w_mask = '0;
        case (i_width)
            WIDTH_8:  w_mask = W'(MASK_8);
            WIDTH_16: w_mask = W'(MASK_16);
            WIDTH_32: w_mask = W'(MASK_32);
            default:  w_mask = '0;
        endcase
    end

    assign o_data = i_data & w_mask;

endmodule

// File: rtl/ecc_op_ctrl.sv
// Sequences encode / decode / full-channel operations around an external registered codec.
module ecc_op_ctrl
    import ecc_pkg::*;
#(
    parameter int AMBA_WORD = 32
) (
    input  logic         clk,
    input  logic         rst,
    ecc_op_ctrl_if.slave bus
);

    state_t                         r_state, w_next;
    logic                           r_arm;
    logic [1:0]                     r_ctrl, r_width;
    logic [AMBA_WORD-1:0]           r_data, r_noise, r_enc_cap, r_data_out;
    logic [1:0]                     r_nerr;
    logic                           r_cfg_err;
    logic                           w_accept, w_rsvd, w_busy, w_done;
    logic [1:0][AMBA_WORD-1:0]      w_mask_in, w_mask_out;

    // r_arm stays low for the first edge after reset so a start held across release is dropped.
    assign w_accept = bus.start && r_arm && (r_state == IDLE);
    assign w_rsvd   = (bus.ctrl == CTRL_RSVD) || (bus.codeword_width == WIDTH_RSVD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_arm   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_arm   <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b1;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (w_accept) begin
                    if (w_rsvd)                    w_next = DONE;
                    else if (bus.ctrl == CTRL_DEC) w_next = DEC_ISSUE;
                    else                           w_next = ENC_ISSUE;
                end
            end
            ENC_ISSUE:   w_next = ENC_CAPTURE;
            ENC_CAPTURE: w_next = (r_ctrl == CTRL_FULL) ? DEC_ISSUE : DONE;
            DEC_ISSUE:   w_next = DEC_CAPTURE;
            DEC_CAPTURE: w_next = DONE;
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Results land in the output registers on the edge entering DONE, so they are
    // valid together with operation_done and hold until the next completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl     <= '0;
            r_width    <= '0;
            r_data     <= '0;
            r_noise    <= '0;
            r_enc_cap  <= '0;
            r_data_out <= '0;
            r_nerr     <= '0;
            r_cfg_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ctrl  <= bus.ctrl;
                r_width <= bus.codeword_width;
                r_data  <= bus.data_in;
                r_noise <= bus.noise;
            end
            if (w_accept && w_rsvd) begin
                r_data_out <= '0;
                r_nerr     <= '0;
                r_cfg_err  <= 1'b1;
            end
            if (r_state == ENC_CAPTURE) begin
                r_enc_cap <= bus.enc_out;
                if (r_ctrl == CTRL_ENC) begin
                    r_data_out <= bus.enc_out;
                    r_nerr     <= '0;
                    r_cfg_err  <= 1'b0;
                end
            end
            if (r_state == DEC_CAPTURE) begin
                r_data_out <= bus.dec_out;
                r_nerr     <= bus.dec_nerr;
                r_cfg_err  <= 1'b0;
            end
        end
    end

    // Lane 0 feeds the encoder, lane 1 the decoder (noise only in full-channel mode).
    assign w_mask_in[0] = r_data;
    assign w_mask_in[1] = (r_ctrl == CTRL_FULL) ? (r_enc_cap ^ r_noise) : r_data;

    for (genvar g = 0; g < 2; g++) begin : g_mask
        ecc_width_mask #(.W(AMBA_WORD)) u_mask (
            .i_data  (w_mask_in[g]),
            .i_width (r_width),
            .o_data  (w_mask_out[g])
        );
    end

    assign bus.enc_data       = w_mask_out[0];
    assign bus.dec_data       = w_mask_out[1];
    assign bus.enc_width      = r_width;
    assign bus.busy           = w_busy;
    assign bus.operation_done = w_done;
    assign bus.data_out       = r_data_out;
    assign bus.num_of_errors  = r_nerr;
    assign bus.cfg_err        = r_cfg_err;

endmodule

// File: tb/tb_ecc_op_ctrl.sv
// Bench for ecc_op_ctrl: stub codec, operation-level reference model, per-cycle compare.
module tb_ecc_op_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ecc_op_ctrl_if #(.AMBA_WORD(32)) bus ();

    ecc_op_ctrl #(.AMBA_WORD(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] wmask(input logic [1:0] w);
        case (w)
            2'd0:    return 32'h0000_00FF;
            2'd1:    return 32'h0000_FFFF;
            2'd2:    return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] enc_f(input logic [31:0] d, input logic [1:0] w);
        return (d ^ 32'hC3C3_C3C3) & wmask(w);
    endfunction

    function automatic logic [31:0] dec_f(input logic [31:0] d, input logic [1:0] w);
        return (d ^ 32'h0F0F_0F0F) & wmask(w);
    endfunction

    function automatic logic [1:0] nerr_f(input logic [31:0] d);
        return 2'($countones(d[11:8]));
    endfunction

    // Registered codec stubs
    always @(posedge clk) begin
        bus.enc_out  <= enc_f(bus.enc_data, bus.enc_width);
        bus.dec_out  <= dec_f(bus.dec_data, bus.enc_width);
        bus.dec_nerr <= nerr_f(bus.dec_data);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Operation-level reference: result, error count, cfg flag, latency in edges
    function automatic void predict(input logic [1:0] c, input logic [1:0] w,
                                    input logic [31:0] d, input logic [31:0] n,
                                    output logic [31:0] o, output logic [1:0] ne,
                                    output logic cf, output int lat);
        logic [31:0] m, dd;
        m = wmask(w);
        o = '0; ne = '0; cf = 1'b0; lat = 3;
        if (c == 2'd3 || w == 2'd3) begin
            cf = 1'b1; lat = 1;
        end else if (c == 2'd0) begin
            o = enc_f(d & m, w);
        end else if (c == 2'd1) begin
            o = dec_f(d & m, w); ne = nerr_f(d & m);
        end else begin
            dd = (enc_f(d & m, w) ^ n) & m;
            o = dec_f(dd, w); ne = nerr_f(dd); lat = 5;
        end
    endfunction

    int          pend_start = -100, pend_done = -100, last_done = -100, armed_from = 1 << 30;
    logic [1:0]  pend_c, pend_w, pend_ne, lat_c, lat_w, cur_ne;
    logic [31:0] pend_d, pend_n, pend_out, lat_d, lat_n, cur_out;
    logic        pend_cf, cur_cf;

    task automatic model_reset();
        pend_start = -100; pend_done = -100; last_done = -100;
        lat_c = '0; lat_w = '0; lat_d = '0; lat_n = '0;
        cur_out = '0; cur_ne = '0; cur_cf = 1'b0;
    endtask

    // One cycle of stimulus, applied 1 time unit after the rising edge.
    task automatic drive(input bit s, input logic [1:0] c, input logic [1:0] w,
                         input logic [31:0] d, input logic [31:0] n);
        int e, lat;
        bus.start = s; bus.ctrl = c; bus.codeword_width = w; bus.data_in = d; bus.noise = n;
        e = cyc + 1;
        if (s && rst && e >= armed_from && e >= last_done + 2) begin
            predict(c, w, d, n, pend_out, pend_ne, pend_cf, lat);
            pend_c = c; pend_w = w; pend_d = d; pend_n = n;
            pend_start = e;
            pend_done  = e + lat - 1;
            last_done  = pend_done;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] c, input logic [1:0] w, input logic [31:0] d,
                          input logic [31:0] n, output int lat,
                          output logic [31:0] enc_snap, output logic [31:0] dec_snap);
        int e;
        lat = -1; enc_snap = '0; dec_snap = '0;
        drive(1, c, w, d, n);
        e = cyc;
        for (int i = 0; i < 10; i++) begin
            if (cyc == e)     enc_snap = bus.enc_data;
            if (cyc == e + 2) dec_snap = bus.dec_data;
            if (bus.operation_done) begin
                lat = cyc - e + 1;
                break;
            end
            drive(0, c, w, $urandom, $urandom);
        end
        drive(0, 2'd0, 2'd0, 32'h0, 32'h0);
    endtask

    always @(negedge clk) begin
        int e;
        logic [31:0] m;
        if (!rst) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.operation_done, 0);
            chk("rst_data_out", bus.data_out, 0);
            chk("rst_nerr", bus.num_of_errors, 0);
            chk("rst_cfg_err", bus.cfg_err, 0);
            chk("rst_enc_data", bus.enc_data, 0);
            chk("rst_dec_data", bus.dec_data, 0);
            chk("rst_enc_width", bus.enc_width, 0);
        end else begin
            e = cyc;
            if (e == pend_start) begin
                lat_c = pend_c; lat_w = pend_w; lat_d = pend_d; lat_n = pend_n;
            end
            if (e == pend_done) begin
                cur_out = pend_out; cur_ne = pend_ne; cur_cf = pend_cf;
            end
            chk("operation_done", bus.operation_done, e == pend_done);
            chk("busy", bus.busy, e >= pend_start && e <= pend_done);
            chk("data_out", bus.data_out, cur_out);
            chk("num_of_errors", bus.num_of_errors, cur_ne);
            chk("cfg_err", bus.cfg_err, cur_cf);
            chk("enc_width", bus.enc_width, lat_w);
            if (lat_w != 2'd3) begin
                m = wmask(lat_w);
                chk("enc_data", bus.enc_data, lat_d & m);
                if (lat_c == 2'd1 && e == pend_start)
                    chk("dec_data_decode", bus.dec_data, lat_d & m);
                if (lat_c == 2'd2 && e == pend_start + 2)
                    chk("dec_data_full", bus.dec_data, (enc_f(lat_d & m, lat_w) ^ lat_n) & m);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not reach the end, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int lat, nd;
        logic [31:0] es, ds;
        logic [1:0] c, w;
        logic [31:0] d, n;
        bus.start = 0; bus.ctrl = 0; bus.codeword_width = 0; bus.data_in = 0; bus.noise = 0;
        model_reset();
        #1 rst = 1'b0;
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_data_out", bus.data_out, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; armed_from = cyc + 2;
        drive(0, 2'd0, 2'd0, 32'h0, 32'h0);

        // encode, 8-bit
        run_op(2'd0, 2'd0, 32'h1234_56A5, 32'h0, lat, es, ds);
        chk("enc8_latency", lat, 3);
        chk("enc8_enc_data", es, 32'h0000_00A5);
        chk("enc8_data_out", bus.data_out, 32'h0000_0066);
        chk("enc8_nerr", bus.num_of_errors, 0);

        // full channel, 32-bit, single flipped bit
        run_op(2'd2, 2'd2, 32'h1234_0311, 32'h0000_0100, lat, es, ds);
        chk("full_latency", lat, 5);
        chk("full_dec_data", ds, 32'hD1F7_C1D2);
        chk("full_data_out", bus.data_out, 32'hDEF8_CEDD);
        chk("full_nerr", bus.num_of_errors, 1);

        // reserved ctrl
        run_op(2'd3, 2'd0, 32'hFFFF_FFFF, 32'h0, lat, es, ds);
        chk("rsvd_ctrl_latency", lat, 1);
        chk("rsvd_ctrl_cfg_err", bus.cfg_err, 1);
        chk("rsvd_ctrl_data_out", bus.data_out, 0);

        // second start during ENC_CAPTURE must be ignored
        drive(1, 2'd0, 2'd2, 32'hCAFE_F00D, 32'h0);
        drive(0, 2'd1, 2'd1, $urandom, $urandom);
        drive(1, 2'd1, 2'd1, 32'h55AA_55AA, 32'h0000_FFFF);
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.operation_done) nd++;
            drive(0, 2'd0, 2'd0, $urandom, $urandom);
        end
        chk("ignored_start_done_count", nd, 1);
        chk("ignored_start_data_out", bus.data_out, 32'h093D_33CE);

        // reset while in DEC_ISSUE
        drive(1, 2'd1, 2'd1, 32'h0000_BEEF, 32'h0);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.operation_done, 0);
        chk("midrst_data_out", bus.data_out, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        // start already high at release is dropped
        rst = 1'b1; armed_from = cyc + 2;
        drive(1, 2'd0, 2'd2, 32'hFFFF_FFFF, 32'h0);
        drive(0, 2'd0, 2'd0, 32'h0, 32'h0);
        chk("release_start_busy", bus.busy, 0);
        run_op(2'd1, 2'd1, 32'h0000_BEEF, 32'h0, lat, es, ds);
        chk("post_rst_dec_latency", lat, 3);
        chk("post_rst_dec_data_out", bus.data_out, 32'h0000_B1E0);
        chk("post_rst_dec_nerr", bus.num_of_errors, 3);

        // reserved width
        run_op(2'd0, 2'd3, 32'h0000_1234, 32'h0, lat, es, ds);
        chk("rsvd_width_latency", lat, 1);
        chk("rsvd_width_cfg_err", bus.cfg_err, 1);
        chk("rsvd_width_data_out", bus.data_out, 0);

        // randomized traffic, including starts while busy and back-to-back requests
        for (int i = 0; i < 1500; i++) begin
            c = ($urandom % 8 < 7) ? 2'($urandom % 3) : 2'd3;
            w = ($urandom % 8 < 7) ? 2'($urandom % 3) : 2'd3;
            d = $urandom;
            n = ($urandom % 2 == 0) ? (32'h1 << ($urandom % 32)) : 32'($urandom);
            drive(($urandom % 3) == 0, c, w, d, n);
        end
        repeat (8) drive(0, 2'd0, 2'd0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ecc_op_ctrl.md
ECC_OP_CTRL -- requirements
Module: ecc_op_ctrl

Interface
REQ-001 SHALL have parameter AMBA_WORD, default 32, meaning the datapath word width in bits.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low; it is the only reset.
REQ-004 SHALL have port start  input  1  one-cycle operation request.
REQ-005 SHALL have port ctrl  input  2  operation code: 0 = encode, 1 = decode, 2 = full channel, 3 = reserved.
REQ-006 SHALL have port codeword_width  input  2  codeword width: 0 = 8 bit, 1 = 16 bit, 2 = 32 bit, 3 = reserved.
REQ-007 SHALL have port data_in  input  AMBA_WORD  operand data.
REQ-008 SHALL have port noise  input  AMBA_WORD  error pattern used in full-channel mode.
REQ-009 SHALL have port enc_data  output  AMBA_WORD  operand driven to the encoder.
REQ-010 SHALL have port enc_width  output  2  width code driven to the encoder and decoder.
REQ-011 SHALL have port enc_out  input  AMBA_WORD  registered encoder result.
REQ-012 SHALL have port dec_data  output  AMBA_WORD  codeword driven to the decoder.
REQ-013 SHALL have port dec_out  input  AMBA_WORD  registered decoder result.
REQ-014 SHALL have port dec_nerr  input  2  registered decoder error count.
REQ-015 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-016 SHALL have port data_out  output  AMBA_WORD  operation result.
REQ-017 SHALL have port num_of_errors  output  2  decoder error count for the last operation.
REQ-018 SHALL have port cfg_err  output  1  last request used a reserved code.
REQ-019 SHALL have port operation_done  output  1  one-cycle completion pulse.

Function
REQ-020 SHALL implement FSM states IDLE, ENC_ISSUE, ENC_CAPTURE, DEC_ISSUE, DEC_CAPTURE, DONE.
REQ-021 SHALL accept start only in IDLE; there it latches ctrl, codeword_width, data_in and noise; start in any other state is ignored, with no effect on the latched operands.
REQ-022 SHALL route an accepted start from IDLE as follows: ctrl 0 or 2 -> ENC_ISSUE; ctrl 1 -> DEC_ISSUE; ctrl 3 or codeword_width 3 -> DONE with cfg_err = 1.
REQ-023 SHALL drive enc_data = latched data_in masked to the low 8/16/32 bits per width; enc_width = latched width.
REQ-024 SHALL move ENC_ISSUE -> ENC_CAPTURE unconditionally; ENC_ISSUE is the cycle in which the encoder samples.
REQ-025 SHALL in ENC_CAPTURE register enc_out, then go to DONE for ctrl 0 or to DEC_ISSUE for ctrl 2.
REQ-026 SHALL drive dec_data = (captured enc_out XOR latched noise) masked to width for ctrl 2, and masked latched data_in for ctrl 1 (no noise applied).
REQ-027 SHALL move DEC_ISSUE -> DEC_CAPTURE unconditionally; in DEC_CAPTURE it registers dec_out and dec_nerr, then goes to DONE.
REQ-028 SHALL in DONE drive operation_done = 1 for exactly one cycle, update data_out and num_of_errors, then return to IDLE.
REQ-029 SHALL set the DONE results per operation: encode -> data_out = enc result, num_of_errors = 0; decode or full -> decoder result and count; reserved -> data_out = 0, num_of_errors = 0.
REQ-030 SHALL hold data_out, num_of_errors and cfg_err stable from DONE until the next DONE.
REQ-031 SHALL meet these latencies, counted as cycles from the start-sampling edge to operation_done high: encode 3, decode 3, full 5, reserved 1.
REQ-032 SHALL accept a start in the cycle immediately after DONE, giving back-to-back operations with no idle gap beyond IDLE.

Reset
REQ-033 SHALL, when rst is low, immediately force state IDLE and clear busy, operation_done, cfg_err, data_out, num_of_errors, enc_data, dec_data, enc_width and all latched registers to 0.
REQ-034 SHALL abandon any operation in progress when reset asserts mid-operation; no operation_done is produced for it.
REQ-035 SHALL ignore start while rst is low and in the first cycle after rst deasserts with start already high.

Structure
REQ-036 SHALL take from shared package ecc_pkg: the state enumeration, the ctrl codes, the width codes and the width-mask constants 0x000000FF, 0x0000FFFF and 0xFFFFFFFF.
REQ-037 SHALL instantiate a single sub-module ecc_width_mask (combinational word masking by width code), used for both enc_data and dec_data.

Verification
REQ-038 SHALL pass: encode, width 0, data_in 0x123456A5, start at edge k -> enc_data = 0x000000A5; operation_done high cycle k+3; data_out = encoder model result; num_of_errors = 0.
REQ-039 SHALL pass: full channel, width 2, noise 0x00000100, stub decoder -> dec_data = enc_out ^ 0x100; operation_done at k+5; num_of_errors = dec_nerr (1).
REQ-040 SHALL pass: ctrl 3, then separately width 3 -> operation_done at k+1, cfg_err = 1, data_out = 0.
REQ-041 SHALL pass: second start pulsed in ENC_CAPTURE -> ignored; exactly one operation_done; latched data unchanged.
REQ-042 SHALL pass: rst low during DEC_ISSUE -> busy = 0 immediately, all outputs 0, no operation_done; a new decode afterwards completes in 3 cycles.
